ttio_icb_bridge: RTL and testbench
==================================

Name: ttio_icb_bridge

Overview:
- Sits directly downstream of the TTIO unit's ICB master port and upstream of the LSU-ctrl ICB slave port.
- Decouples TTIO from LSU-ctrl back-pressure with a small command queue.
- Tracks outstanding transactions in order and returns responses to TTIO tagged with the originating itag.
- Discards responses belonging to flushed commands and flags LSU responses that never arrive.

Parameters:
- XLEN, 32, data and address width
- ITAG_W, 1, instruction tag width
- CMD_DEPTH, 2, command queue entries (power of two, >=2)
- MAX_OUTS, 2, max issued-but-unresponded commands (power of two, >=1)
- TIMEOUT, 1024, cycles the oldest outstanding command may wait for a response before timeout_err sets

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- i_cmd_valid  in  1  TTIO command valid
- i_cmd_ready  out  1  bridge can accept a command
- i_cmd_addr  in  XLEN  byte address
- i_cmd_read  in  1  1=load, 0=store
- i_cmd_wdata  in  XLEN  store data
- i_cmd_wmask  in  XLEN/8  byte enables
- i_cmd_size  in  2  access size
- i_cmd_usign  in  1  unsigned load
- i_cmd_itag  in  ITAG_W  instruction tag
- i_rsp_valid  out  1  response to TTIO valid
- i_rsp_ready  in  1  TTIO accepts response
- i_rsp_err  out  1  bus error
- i_rsp_rdata  out  XLEN  load data
- i_rsp_itag  out  ITAG_W  tag of responding command
- flush_pulse  in  1  pipeline flush, single cycle
- o_cmd_valid, o_cmd_ready, o_cmd_addr, o_cmd_read, o_cmd_wdata, o_cmd_wmask, o_cmd_size, o_cmd_usign: out/in/out...: same widths as i_cmd_*; command to LSU-ctrl
- o_rsp_valid  in  1, o_rsp_ready  out  1, o_rsp_err  in  1, o_rsp_rdata  in  XLEN: response from LSU-ctrl
- busy  out  1  queue non-empty or commands outstanding
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst high, async): both queues empty, outstanding count 0, timeout counter 0, timeout_err=0.
  - Resulting outputs: i_cmd_ready=1, o_cmd_valid=0, o_rsp_ready=0, i_rsp_valid=0, busy=0.
  - Reset asserted mid-transaction discards all state; late LSU responses after reset are a protocol violation and are not handled.
- Command queue: CMD_DEPTH-entry FIFO; read/write pointers carry one extra wrap bit.
  - full = pointers equal except wrap bit; empty = pointers fully equal.
  - i_cmd_ready = ~full & ~flush_pulse; it depends only on registered state and flush, so a push into a full queue is refused even if a pop happens the same cycle.
  - Push on i_cmd_valid & i_cmd_ready.
- Issue:
  - o_cmd_valid = ~empty & (outs_cnt < MAX_OUTS) & ~flush_pulse; o_cmd_* driven from the queue head.
  - Pop on o_cmd_valid & o_cmd_ready. Zero-latency pass is not provided: a command issues at the earliest one cycle after its push.
- Tag queue: MAX_OUTS-entry FIFO of {kill, itag}; written on issue with kill=0.
  - outs_cnt = occupancy.
  - Issue and response retire in the same cycle: count unchanged.
- Response routing, combinational, head of tag queue:
  - Tag queue empty: o_rsp_ready=0, i_rsp_valid=0.
  - Head kill=0: i_rsp_valid = o_rsp_valid, o_rsp_ready = i_rsp_ready; err/rdata pass through; i_rsp_itag = head itag.
  - Head kill=1: o_rsp_ready=1, i_rsp_valid=0; the response is silently consumed.
  - Retire head on o_rsp_valid & o_rsp_ready.
- Flush (flush_pulse=1):
  - Command queue emptied at the next edge.
  - Every tag-queue entry gets kill=1, including entries not retiring that cycle.
  - No push or issue in the flush cycle.
  - A response retiring in the flush cycle is forwarded normally, since its kill bit was still 0.
  - timeout_err cleared.
- Timeout:
  - The counter increments each cycle while outs_cnt != 0 and no retire occurs; it clears on retire or when outs_cnt == 0.
  - On reaching TIMEOUT-1 with no retire: timeout_err sets and stays set until flush_pulse or rst.
  - The counter saturates and does not wrap; no synthetic response is generated.
- busy = ~empty | (outs_cnt != 0).
- Stores get a response like loads; rdata is passed unchanged, with no width manipulation anywhere.

Decomposition:
- Shared package: ICB command field widths, size encodings (00 byte, 01 half, 10 word), and the tag-entry layout.
- One natural sub-module: ttio_bridge_fifo, a generic parameterised-width/depth FIFO with a wrap-bit pointer. It is instantiated twice: command queue (command payload) and tag queue (kill+itag). The tag queue needs an extra "set all kill bits" input.

Test Plan:
- Reset, then push load addr 0x1000 itag=1 with o_cmd_ready=1 -> o_cmd_valid one cycle later with addr 0x1000; LSU returns rdata 0xDEADBEEF -> i_rsp_valid with rdata 0xDEADBEEF, itag=1.
- Hold o_cmd_ready=0, push 3 commands -> first two accepted, i_cmd_ready=0 on the third until a pop occurs; issue order preserved.
- Issue 2 commands and withhold responses -> o_cmd_valid=0 for a queued third command until one response retires; the same-cycle retire+issue keeps outs_cnt=2.
- Issue 2 commands, pulse flush, then LSU returns 2 responses -> both consumed (o_rsp_ready=1), i_rsp_valid never asserts; the queued unissued command is gone and busy=0 afterwards.
- Issue 1 command and withhold the response with TIMEOUT=16 -> timeout_err rises after 16 cycles and stays set; flush_pulse clears it.
- Response arrives while i_rsp_ready=0 -> o_rsp_ready=0, head not retired; completes when i_rsp_ready goes to 1.

Source files
------------

// File: rtl/ttio_icb_bridge_pkg.sv
// Shared definitions for the TTIO-to-LSU ICB bridge: field widths, size
// encodings and queue entry layouts.
package ttio_icb_bridge_pkg;

    localparam int ICB_SIZE_W = 2;

    typedef enum logic [ICB_SIZE_W-1:0] {
        ICB_SIZE_BYTE = 2'b00,
        ICB_SIZE_HALF = 2'b01,
        ICB_SIZE_WORD = 2'b10
    } icb_size_e;

    // Tag-queue entry is {kill, itag}: kill flag sits in the MSB.
    function automatic int tag_entry_w(input int itag_w);
        return itag_w + 1;
    endfunction

    // Command payload is {addr, read, wdata, wmask, size, usign, itag}.
    function automatic int cmd_payload_w(input int xlen, input int itag_w);
        return 2 * xlen + xlen / 8 + ICB_SIZE_W + 2 + itag_w;
    endfunction

endpackage

// File: rtl/ttio_icb_bridge_if.sv
// ICB signal bundle between TTIO, the bridge and LSU-ctrl; the bridge uses
// the slave view, the surrounding environment the master view.
interface ttio_icb_bridge_if
    import ttio_icb_bridge_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ITAG_W = 1
) ();

    logic                  i_cmd_valid;
    logic                  i_cmd_ready;
    logic [XLEN-1:0]       i_cmd_addr;
    logic                  i_cmd_read;
    logic [XLEN-1:0]       i_cmd_wdata;
    logic [XLEN/8-1:0]     i_cmd_wmask;
    logic [ICB_SIZE_W-1:0] i_cmd_size;
    logic                  i_cmd_usign;
    logic [ITAG_W-1:0]     i_cmd_itag;
    logic                  i_rsp_valid;
    logic                  i_rsp_ready;
    logic                  i_rsp_err;
    logic [XLEN-1:0]       i_rsp_rdata;
    logic [ITAG_W-1:0]     i_rsp_itag;

    logic                  o_cmd_valid;
    logic                  o_cmd_ready;
    logic [XLEN-1:0]       o_cmd_addr;
    logic                  o_cmd_read;
    logic [XLEN-1:0]       o_cmd_wdata;
    logic [XLEN/8-1:0]     o_cmd_wmask;
    logic [ICB_SIZE_W-1:0] o_cmd_size;
    logic                  o_cmd_usign;
    logic                  o_rsp_valid;
    logic                  o_rsp_ready;
    logic                  o_rsp_err;
    logic [XLEN-1:0]       o_rsp_rdata;

    modport slave (
        input  i_cmd_valid, i_cmd_addr, i_cmd_read, i_cmd_wdata, i_cmd_wmask,
               i_cmd_size, i_cmd_usign, i_cmd_itag, i_rsp_ready,
        output i_cmd_ready, i_rsp_valid, i_rsp_err, i_rsp_rdata, i_rsp_itag,
        output o_cmd_valid, o_cmd_addr, o_cmd_read, o_cmd_wdata, o_cmd_wmask,
               o_cmd_size, o_cmd_usign, o_rsp_ready,
        input  o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata
    );

    modport master (
        output i_cmd_valid, i_cmd_addr, i_cmd_read, i_cmd_wdata, i_cmd_wmask,
               i_cmd_size, i_cmd_usign, i_cmd_itag, i_rsp_ready,
        input  i_cmd_ready, i_rsp_valid, i_rsp_err, i_rsp_rdata, i_rsp_itag,
        input  o_cmd_valid, o_cmd_addr, o_cmd_read, o_cmd_wdata, o_cmd_wmask,
               o_cmd_size, o_cmd_usign, o_rsp_ready,
        output o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata
    );

endinterface

// File: rtl/ttio_bridge_fifo.sv
// Generic FIFO with wrap-bit pointers; kill_all sets the MSB of every
// stored entry (used to mark flushed tags).
module ttio_bridge_fifo
    import ttio_icb_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    input  logic             kill_all,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (AW > 0) ? AW : 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic [WIDTH-1:0] mem [DEPTH];

    generate
        if (AW > 0) begin : g_idx
            assign wr_idx = wr_ptr[AW-1:0];
            assign rd_idx = rd_ptr[AW-1:0];
        end else begin : g_single
            assign wr_idx = '0;
            assign rd_idx = '0;
        end
    endgenerate

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign head  = mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Callers never push in the same cycle as kill_all, so order is moot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (kill_all) begin
                for (int i = 0; i < DEPTH; i++) mem[i][WIDTH-1] <= 1'b1;
            end
            if (push) mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/ttio_icb_bridge.sv
// Bridge between the TTIO ICB master and LSU-ctrl: queues commands, tracks
// outstanding tags in order, drops flushed responses and flags lost ones.
module ttio_icb_bridge
    import ttio_icb_bridge_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ITAG_W    = 1,
    parameter int CMD_DEPTH = 2,
    parameter int MAX_OUTS  = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    ttio_icb_bridge_if.slave     bus,
    input  logic                 flush_pulse,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int CMD_W = cmd_payload_w(XLEN, ITAG_W);
    localparam int TAG_W = tag_entry_w(ITAG_W);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CMD_W-1:0]  cmd_in;
    logic [CMD_W-1:0]  cmd_head;
    logic [ITAG_W-1:0] head_itag;
    logic [TAG_W-1:0]  tag_head;
    logic              cmd_full, cmd_empty, tag_full, tag_empty;
    logic              push_cmd, issue, retire, head_kill;
    logic [CNT_W-1:0]  wait_cnt;

    assign cmd_in = {bus.i_cmd_addr, bus.i_cmd_read, bus.i_cmd_wdata, bus.i_cmd_wmask,
                     bus.i_cmd_size, bus.i_cmd_usign, bus.i_cmd_itag};
    assign {bus.o_cmd_addr, bus.o_cmd_read, bus.o_cmd_wdata, bus.o_cmd_wmask,
            bus.o_cmd_size, bus.o_cmd_usign, head_itag} = cmd_head;

    // Ready/valid look only at registered occupancy so a full queue never
    // accepts on the strength of a same-cycle pop.
    assign bus.i_cmd_ready = ~cmd_full & ~flush_pulse;
    assign push_cmd        = bus.i_cmd_valid & bus.i_cmd_ready;
    assign bus.o_cmd_valid = ~cmd_empty & ~tag_full & ~flush_pulse;
    assign issue           = bus.o_cmd_valid & bus.o_cmd_ready;

    assign head_kill       = tag_head[TAG_W-1];
    assign bus.o_rsp_ready = ~tag_empty & (head_kill | bus.i_rsp_ready);
    assign bus.i_rsp_valid = ~tag_empty & ~head_kill & bus.o_rsp_valid;
    assign bus.i_rsp_err   = bus.o_rsp_err;
    assign bus.i_rsp_rdata = bus.o_rsp_rdata;
    assign bus.i_rsp_itag  = tag_head[ITAG_W-1:0];
    assign retire          = bus.o_rsp_valid & bus.o_rsp_ready;

    assign busy = ~cmd_empty | ~tag_empty;

    ttio_bridge_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_q (
        .clk       (clk),
        .rst       (rst),
        .push      (push_cmd),
        .push_data (cmd_in),
        .pop       (issue),
        .clear     (flush_pulse),
        .kill_all  (1'b0),
        .head      (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty)
    );

    ttio_bridge_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUTS)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data ({1'b0, head_itag}),
        .pop       (retire),
        .clear     (1'b0),
        .kill_all  (flush_pulse),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    // Age of the oldest outstanding command; saturates rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (tag_empty || retire) begin
                wait_cnt <= '0;
            end else if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + CNT_ONE;
            end
            if (flush_pulse) begin
                timeout_err <= 1'b0;
            end else if (!tag_empty && !retire && wait_cnt == CNT_MAX) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ttio_icb_bridge.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_ttio_icb_bridge;
    import ttio_icb_bridge_pkg::*;

    localparam int XLEN      = 32;
    localparam int ITAG_W    = 1;
    localparam int CMD_DEPTH = 2;
    localparam int MAX_OUTS  = 2;
    localparam int TIMEOUT   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_pulse = 1'b0;
    logic busy;
    logic timeout_err;

    ttio_icb_bridge_if #(.XLEN(XLEN), .ITAG_W(ITAG_W)) bus ();

    ttio_icb_bridge #(
        .XLEN(XLEN), .ITAG_W(ITAG_W), .CMD_DEPTH(CMD_DEPTH),
        .MAX_OUTS(MAX_OUTS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .flush_pulse (flush_pulse),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]   addr;
        logic              read;
        logic [XLEN-1:0]   wdata;
        logic [XLEN/8-1:0] wmask;
        logic [1:0]        size;
        logic              usign;
        logic [ITAG_W-1:0] itag;
    } cmd_t;

    typedef struct {
        logic              kill;
        logic [ITAG_W-1:0] itag;
    } tag_t;

    cmd_t cmdq[$];
    tag_t tagq[$];
    int   cycle_no   = 0;
    int   wait_start = 0;
    logic m_terr     = 1'b0;
    int   errors     = 0;
    int   checks     = 0;

    cmd_t c_new, c_iss;
    logic exp_icr, exp_ocv, exp_orr, exp_irv, outs_nz, do_push, do_issue, do_retire;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluates the bridge's rules on queues, then advances.
    task automatic modelStep();
        outs_nz = (tagq.size() != 0);
        exp_icr = (cmdq.size() < CMD_DEPTH) && !flush_pulse;
        exp_ocv = (cmdq.size() != 0) && (tagq.size() < MAX_OUTS) && !flush_pulse;
        exp_orr = outs_nz && (tagq[0].kill || bus.i_rsp_ready);
        exp_irv = outs_nz && !tagq[0].kill && bus.o_rsp_valid;

        checkOutput("i_cmd_ready", bus.i_cmd_ready, exp_icr);
        checkOutput("o_cmd_valid", bus.o_cmd_valid, exp_ocv);
        checkOutput("o_rsp_ready", bus.o_rsp_ready, exp_orr);
        checkOutput("i_rsp_valid", bus.i_rsp_valid, exp_irv);
        checkOutput("busy", busy, (cmdq.size() != 0) || outs_nz);
        checkOutput("timeout_err", timeout_err, m_terr);
        if (exp_ocv) begin
            checkOutput("o_cmd_addr", bus.o_cmd_addr, cmdq[0].addr);
            checkOutput("o_cmd_ctl", {bus.o_cmd_read, bus.o_cmd_wmask, bus.o_cmd_size, bus.o_cmd_usign},
                        {cmdq[0].read, cmdq[0].wmask, cmdq[0].size, cmdq[0].usign});
            checkOutput("o_cmd_wdata", bus.o_cmd_wdata, cmdq[0].wdata);
        end
        if (exp_irv) begin
            checkOutput("i_rsp_rdata", bus.i_rsp_rdata, bus.o_rsp_rdata);
            checkOutput("i_rsp_err", bus.i_rsp_err, bus.o_rsp_err);
            checkOutput("i_rsp_itag", bus.i_rsp_itag, tagq[0].itag);
        end

        do_push   = bus.i_cmd_valid && exp_icr;
        do_issue  = exp_ocv && bus.o_cmd_ready;
        do_retire = outs_nz && bus.o_rsp_valid && exp_orr;

        if (flush_pulse) m_terr = 1'b0;
        else if (outs_nz && !do_retire && (cycle_no - wait_start) >= TIMEOUT - 1) m_terr = 1'b1;
        if (!outs_nz || do_retire) wait_start = cycle_no + 1;

        if (do_retire) void'(tagq.pop_front());
        if (flush_pulse) begin
            cmdq.delete();
            foreach (tagq[i]) tagq[i].kill = 1'b1;
        end else begin
            if (do_issue) begin
                c_iss = cmdq.pop_front();
                tagq.push_back('{kill: 1'b0, itag: c_iss.itag});
            end
            if (do_push) begin
                c_new.addr  = bus.i_cmd_addr;
                c_new.read  = bus.i_cmd_read;
                c_new.wdata = bus.i_cmd_wdata;
                c_new.wmask = bus.i_cmd_wmask;
                c_new.size  = bus.i_cmd_size;
                c_new.usign = bus.i_cmd_usign;
                c_new.itag  = bus.i_cmd_itag;
                cmdq.push_back(c_new);
            end
        end
    endtask

    always @(negedge clk) begin
        cycle_no++;
        if (rst) begin
            cmdq.delete();
            tagq.delete();
            m_terr     = 1'b0;
            wait_start = cycle_no + 1;
        end else begin
            modelStep();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cv, input logic [XLEN-1:0] addr, input logic [ITAG_W-1:0] itag,
                                 input logic rd, input logic ocr, input logic orv,
                                 input logic [XLEN-1:0] rdata, input logic irr, input logic fl);
        bus.i_cmd_valid = cv;
        bus.i_cmd_addr  = addr;
        bus.i_cmd_itag  = itag;
        bus.i_cmd_read  = rd;
        bus.i_cmd_wdata = $urandom;
        bus.i_cmd_wmask = 4'($urandom);
        bus.i_cmd_size  = icb_size_e'(2'($urandom_range(0, 2)));
        bus.i_cmd_usign = 1'($urandom_range(0, 1));
        bus.o_cmd_ready = ocr;
        bus.o_rsp_valid = orv;
        bus.o_rsp_rdata = rdata;
        bus.o_rsp_err   = ($urandom_range(0, 7) == 0);
        bus.i_rsp_ready = irr;
        flush_pulse     = fl;
    endtask

    task automatic idle(input logic ocr, input logic irr);
        applyStimulus(1'b0, '0, '0, 1'b0, ocr, 1'b0, '0, irr, 1'b0);
    endtask

    task automatic randomCycle(input int rsp_pct);
        tick();
        applyStimulus($urandom_range(0, 99) < 60, $urandom, ITAG_W'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 99) < 70,
                      (tagq.size() != 0) && ($urandom_range(0, 99) < rsp_pct),
                      $urandom, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 3);
    endtask

    initial begin
        idle(1'b1, 1'b1);
        #1;
        checkOutput("reset i_cmd_ready", bus.i_cmd_ready, 1'b1);
        checkOutput("reset o_cmd_valid", bus.o_cmd_valid, 1'b0);
        checkOutput("reset o_rsp_ready", bus.o_rsp_ready, 1'b0);
        checkOutput("reset i_rsp_valid", bus.i_rsp_valid, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset timeout_err", timeout_err, 1'b0);
        tick(); tick();
        rst = 1'b0;

        // Single load round trip.
        tick(); applyStimulus(1'b1, 32'h1000, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0); #1;
        checkOutput("t1 push ready", bus.i_cmd_ready, 1'b1);
        checkOutput("t1 no bypass", bus.o_cmd_valid, 1'b0);
        tick(); idle(1'b1, 1'b1); #1;
        checkOutput("t1 issue valid", bus.o_cmd_valid, 1'b1);
        checkOutput("t1 issue addr", bus.o_cmd_addr, 32'h1000);
        tick(); applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0); #1;
        checkOutput("t1 rsp valid", bus.i_rsp_valid, 1'b1);
        checkOutput("t1 rsp rdata", bus.i_rsp_rdata, 32'hDEADBEEF);
        checkOutput("t1 rsp itag", bus.i_rsp_itag, 1'b1);
        tick(); idle(1'b1, 1'b1); #1;
        checkOutput("t1 idle busy", busy, 1'b0);

        // Queue fill under back-pressure, then outstanding limit.
        tick(); applyStimulus(1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0); #1;
        checkOutput("t2 c0 ready", bus.i_cmd_ready, 1'b1);
        tick(); applyStimulus(1'b1, 32'h2004, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0); #1;
        checkOutput("t2 c1 ready", bus.i_cmd_ready, 1'b1);
        tick(); applyStimulus(1'b1, 32'h2008, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0); #1;
        checkOutput("t2 full refuse", bus.i_cmd_ready, 1'b0);
        tick(); applyStimulus(1'b1, 32'h2008, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0); #1;
        checkOutput("t2 full with pop", bus.i_cmd_ready, 1'b0);
        checkOutput("t2 head c0", bus.o_cmd_addr, 32'h2000);
        tick(); applyStimulus(1'b1, 32'h2008, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0); #1;
        checkOutput("t2 c2 ready", bus.i_cmd_ready, 1'b1);
        checkOutput("t2 head c1", bus.o_cmd_addr, 32'h2004);
        tick(); idle(1'b1, 1'b1); #1;
        checkOutput("t3 outs limit", bus.o_cmd_valid, 1'b0);
        tick(); applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0); #1;
        checkOutput("t3 limit during rsp", bus.o_cmd_valid, 1'b0);
        checkOutput("t3 rsp itag c0", bus.i_rsp_itag, 1'b0);
        tick(); applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 32'h22222222, 1'b1, 1'b0); #1;
        checkOutput("t3 issue after retire", bus.o_cmd_valid, 1'b1);
        checkOutput("t3 head c2", bus.o_cmd_addr, 32'h2008);
        checkOutput("t3 rsp itag c1", bus.i_rsp_itag, 1'b1);
        tick(); applyStimulus(1'b1, 32'h200C, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0); #1;
        checkOutput("t3 queue empty", bus.o_cmd_valid, 1'b0);
        tick(); applyStimulus(1'b1, 32'h2010, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0); #1;
        checkOutput("t3 one outstanding", bus.o_cmd_valid, 1'b1);
        checkOutput("t3 head c3", bus.o_cmd_addr, 32'h200C);
        tick(); idle(1'b1, 1'b0); #1;
        checkOutput("t3 two outstanding", bus.o_cmd_valid, 1'b0);

        // Flush with two issued and one queued command.
        tick(); applyStimulus(1'b1, 32'h2014, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1); #1;
        checkOutput("t4 flush no push", bus.i_cmd_ready, 1'b0);
        checkOutput("t4 flush no issue", bus.o_cmd_valid, 1'b0);
        tick(); idle(1'b1, 1'b0); #1;
        checkOutput("t4 queue dropped", bus.o_cmd_valid, 1'b0);
        checkOutput("t4 killed ready", bus.o_rsp_ready, 1'b1);
        repeat (2) begin
            tick(); applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 32'h33333333, 1'b0, 1'b0); #1;
            checkOutput("t4 consume ready", bus.o_rsp_ready, 1'b1);
            checkOutput("t4 no forward", bus.i_rsp_valid, 1'b0);
        end
        tick(); idle(1'b1, 1'b1); #1;
        checkOutput("t4 busy after", busy, 1'b0);

        // Timeout on a withheld response.
        tick(); applyStimulus(1'b1, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick(); idle(1'b1, 1'b1);
        repeat (16) begin tick(); idle(1'b1, 1'b1); end
        #1 checkOutput("t5 before timeout", timeout_err, 1'b0);
        tick(); idle(1'b1, 1'b1); #1;
        checkOutput("t5 timeout set", timeout_err, 1'b1);
        repeat (3) begin tick(); idle(1'b1, 1'b1); end
        #1 checkOutput("t5 timeout sticky", timeout_err, 1'b1);
        tick(); applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        tick(); applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 32'h44444444, 1'b1, 1'b0); #1;
        checkOutput("t5 flush clears", timeout_err, 1'b0);
        checkOutput("t5 late rsp dropped", bus.i_rsp_valid, 1'b0);
        tick(); idle(1'b1, 1'b1); #1;
        checkOutput("t5 idle", busy, 1'b0);

        // Response held off by TTIO back-pressure.
        tick(); applyStimulus(1'b1, 32'h4000, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick(); idle(1'b1, 1'b0);
        repeat (2) begin
            tick(); applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 32'h55AA55AA, 1'b0, 1'b0); #1;
            checkOutput("t6 held valid", bus.i_rsp_valid, 1'b1);
            checkOutput("t6 held ready", bus.o_rsp_ready, 1'b0);
        end
        tick(); applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 32'h55AA55AA, 1'b1, 1'b0); #1;
        checkOutput("t6 release ready", bus.o_rsp_ready, 1'b1);
        checkOutput("t6 rdata", bus.i_rsp_rdata, 32'h55AA55AA);
        checkOutput("t6 itag", bus.i_rsp_itag, 1'b1);
        tick(); idle(1'b1, 1'b1); #1;
        checkOutput("t6 idle", busy, 1'b0);

        // Randomized traffic, with a mid-run reset and a slow-LSU phase.
        repeat (1500) randomCycle(50);
        tick(); idle(1'b1, 1'b1); rst = 1'b1;
        tick(); rst = 1'b0; #1;
        checkOutput("mid reset busy", busy, 1'b0);
        repeat (1500) randomCycle(8);
        tick(); idle(1'b1, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
